config_frame_fsm: RTL and testbench
===================================

Name: config_frame_fsm

Overview:
- Configuration-write sequencer sitting directly upstream of the per-column frame-select gates.
- Parses a 32-bit configuration word stream: sync word, then per-frame address word, then NumberOfRows data words.
- Drives row-indexed frame data to the frame data registers.
- Produces the shared column select, one-hot frame strobe vector and single-cycle commit strobe that every column's frame-select gate consumes.

Parameters:
- MaxFramesPerCol, 20, frames per column; width of the one-hot FrameStrobe_I vector.
- FrameSelectWidth, 5, width of the column select and of the frame-index field.
- NumColumns, 17, number of valid columns (0..NumColumns-1).
- NumberOfRows, 16, data words per frame (one per row).
- RowSelectWidth, 5, width of RowSelect; must satisfy 2**RowSelectWidth >= NumberOfRows.

Ports:
- CLK  in  1  single system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- WriteData  in  32  configuration word.
- WriteStrobe  in  1  WriteData valid this cycle; single-cycle qualifier; no backpressure, block always accepts.
- FrameData  out  32  registered row data word.
- RowSelect  out  RowSelectWidth  row index of FrameData.
- FrameDataValid  out  1  one-cycle pulse qualifying FrameData/RowSelect.
- FrameSelect  out  FrameSelectWidth  column address for the frame-select gates.
- FrameStrobe_I  out  MaxFramesPerCol  one-hot decoded frame index.
- FrameStrobe  out  1  one-cycle commit pulse.
- ConfigError  out  1  sticky bad-address flag.

Behaviour:
- Reset, asynchronous while resetn=0: all outputs 0; state IDLE; row counter 0.
- Constants: SYNC = 32'hFAB0_FAB1, DESYNC = 32'hFAB0_FAB0.
- IDLE: on a WriteStrobe word equal to SYNC, go to ADDR and clear ConfigError. All other words are ignored.
- ADDR, on a WriteStrobe word:
  - Word = DESYNC: go to IDLE; FrameSelect and FrameStrobe_I unchanged.
  - Otherwise: col = WriteData[31 -: FrameSelectWidth], idx = WriteData[FrameSelectWidth-1:0]. Register FrameSelect=col and FrameStrobe_I = 1<<idx. Set discard flag = (col>=NumColumns)||(idx>=MaxFramesPerCol); if discard, set ConfigError and force FrameStrobe_I=0. Clear row counter; go to DATA.
- DATA, on each WriteStrobe word:
  - Next cycle: FrameData=word, RowSelect=counter, FrameDataValid=1 (latency 1); counter increments.
  - Data words are forwarded even when discard is set.
  - On the word with counter==NumberOfRows-1: go to ADDR. Next cycle, FrameStrobe=1 for exactly one cycle, unless discard is set.
  - FrameStrobe is asserted in the same cycle as the last FrameDataValid.
- No dead cycle: a WriteStrobe arriving in the cycle FrameStrobe is high is processed as the next address word.
- FrameSelect and FrameStrobe_I hold from address latch until the next address word; they are stable while FrameStrobe is high.
- WriteStrobe=0: no state change; FrameDataValid and FrameStrobe return to 0.
- SYNC received in DATA is treated as data, not resync.
- Reset mid-frame discards the partial frame; no FrameStrobe is produced.
- ConfigError clears only on reset or a new SYNC.

Optional Feature:
- Macro CONFIG_FRAME_COUNT_EN.
- Defined: adds output FrameCount [15:0]. Reset 0; increments on every FrameStrobe pulse; wraps 16'hFFFF -> 0; cleared on SYNC.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package config_pkg:
  - SYNC and DESYNC word constants.
  - FSM state encoding IDLE/ADDR/DATA (2-bit).
  - Address-word field positions.
- One sub-module, config_frame_decode: combinational idx -> one-hot MaxFramesPerCol vector, plus range-check outputs. Reused by frame-select gate testbenches.

Test Plan:
- Full frame: SYNC, addr col=3 idx=7, 16 data words 32'h0..32'hF -> 16 FrameDataValid pulses with RowSelect 0..15. FrameSelect=3 and FrameStrobe_I=20'h00080 throughout. FrameStrobe high 1 cycle, aligned with row 15.
- Back-to-back: second address word (col=16 idx=19) on the cycle FrameStrobe is high -> accepted, no dropped word. Second frame strobes with FrameStrobe_I=20'h80000.
- Bad address: col=17 or idx=20 -> ConfigError=1, FrameStrobe_I=0, rows forwarded, no FrameStrobe. Next SYNC clears ConfigError.
- Pre-sync/desync: data before SYNC -> no outputs. DESYNC in ADDR -> IDLE. Following words ignored until SYNC.
- Gapped strobes: WriteStrobe every 3rd cycle -> identical output sequence, 1-cycle latency per word.
- Reset mid-frame: resetn low after row 8 -> outputs 0 immediately, no FrameStrobe. With CONFIG_FRAME_COUNT_EN: FrameCount=0 after reset; 2 completed frames -> FrameCount=2.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants and state encoding for the configuration-frame write path.
package config_pkg;
  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // Address word: column in the top bits, frame index in the bottom bits.
  localparam int ADDR_COL_MSB = 31;
  localparam int ADDR_IDX_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } cfgState_t;
endpackage

// File: rtl/config_frame_decode.sv
// Frame index to one-hot strobe decode plus column/index range checks.
module config_frame_decode #(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int NumColumns       = 17
) (
  input  logic [FrameSelectWidth-1:0] col,
  input  logic [FrameSelectWidth-1:0] idx,
  output logic [MaxFramesPerCol-1:0]  frameOneHot,
  output logic                        colValid,
  output logic                        idxValid
);
  always_comb begin
    frameOneHot = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      frameOneHot[i] = (int'(idx) == i);
    end
  end

  assign colValid = (int'(col) < NumColumns);
  assign idxValid = (int'(idx) < MaxFramesPerCol);
endmodule

// File: rtl/config_frame_fsm.sv
// Configuration word stream sequencer: SYNC, address word, then one data word per row.
// Optional CONFIG_FRAME_COUNT_EN adds a FrameCount output of committed frames.
//
// state | meaning
// IDLE  | waiting for SYNC, all other words ignored
// ADDR  | next word is a frame address (or DESYNC)
// DATA  | forwarding row words until the last row commits the frame
module config_frame_fsm
  import config_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 5,
  parameter int NumColumns       = 17,
  parameter int NumberOfRows     = 16,
  parameter int RowSelectWidth   = 5
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [31:0]                 WriteData,
  input  logic                        WriteStrobe,
  output logic [31:0]                 FrameData,
  output logic [RowSelectWidth-1:0]   RowSelect,
  output logic                        FrameDataValid,
  output logic [FrameSelectWidth-1:0] FrameSelect,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe_I,
  output logic                        FrameStrobe,
  output logic                        ConfigError
`ifdef CONFIG_FRAME_COUNT_EN
  ,
  output logic [15:0]                 FrameCount
`endif
);
  cfgState_t                  state;
  logic [RowSelectWidth-1:0]  rowCnt;
  logic                       discard;
  logic [FrameSelectWidth-1:0] addrCol;
  logic [FrameSelectWidth-1:0] addrIdx;
  logic [MaxFramesPerCol-1:0] decodedOneHot;
  logic                       colValid;
  logic                       idxValid;
  logic                       addrBad;
  logic                       lastRow;

  assign addrCol = WriteData[ADDR_COL_MSB -: FrameSelectWidth];
  assign addrIdx = WriteData[ADDR_IDX_LSB +: FrameSelectWidth];
  assign addrBad = !(colValid && idxValid);
  assign lastRow = (rowCnt == RowSelectWidth'(NumberOfRows - 1));

  config_frame_decode #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .FrameSelectWidth(FrameSelectWidth),
    .NumColumns      (NumColumns)
  ) uDecode (
    .col        (addrCol),
    .idx        (addrIdx),
    .frameOneHot(decodedOneHot),
    .colValid   (colValid),
    .idxValid   (idxValid)
  );

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      rowCnt         <= '0;
      discard        <= 1'b0;
      FrameData      <= '0;
      RowSelect      <= '0;
      FrameDataValid <= 1'b0;
      FrameSelect    <= '0;
      FrameStrobe_I  <= '0;
      FrameStrobe    <= 1'b0;
      ConfigError    <= 1'b0;
`ifdef CONFIG_FRAME_COUNT_EN
      FrameCount     <= '0;
`endif
    end else begin
      FrameDataValid <= 1'b0;
      FrameStrobe    <= 1'b0;
      if (WriteStrobe) begin
        case (state)
          IDLE: begin
            if (WriteData == SYNC_WORD) begin
              state       <= ADDR;
              ConfigError <= 1'b0;
`ifdef CONFIG_FRAME_COUNT_EN
              FrameCount  <= '0;
`endif
            end
          end
          ADDR: begin
            if (WriteData == DESYNC_WORD) begin
              state <= IDLE;
            end else begin
              FrameSelect   <= addrCol;
              FrameStrobe_I <= addrBad ? '0 : decodedOneHot;
              discard       <= addrBad;
              if (addrBad) ConfigError <= 1'b1;
              rowCnt        <= '0;
              state         <= DATA;
            end
          end
          DATA: begin
            // Rows of a discarded frame are still forwarded; only the commit is suppressed.
            FrameData      <= WriteData;
            RowSelect      <= rowCnt;
            FrameDataValid <= 1'b1;
            rowCnt         <= rowCnt + 1'b1;
            if (lastRow) begin
              state       <= ADDR;
              FrameStrobe <= !discard;
`ifdef CONFIG_FRAME_COUNT_EN
              if (!discard) FrameCount <= FrameCount + 16'd1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_config_frame_fsm.sv
// Scoreboard bench for config_frame_fsm: stimulus pushes expected row outputs, a monitor pops and compares.
module tb_config_frame_fsm;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic        CLK;
  logic        resetn;
  logic [31:0] WriteData;
  logic        WriteStrobe;
  logic [31:0] FrameData;
  logic [4:0]  RowSelect;
  logic        FrameDataValid;
  logic [4:0]  FrameSelect;
  logic [19:0] FrameStrobe_I;
  logic        FrameStrobe;
  logic        ConfigError;
`ifdef CONFIG_FRAME_COUNT_EN
  logic [15:0] FrameCount;
`endif

  config_frame_fsm #(
    .MaxFramesPerCol(20), .FrameSelectWidth(5), .NumColumns(17),
    .NumberOfRows(16), .RowSelectWidth(5)
  ) dut (
    .CLK(CLK), .resetn(resetn), .WriteData(WriteData), .WriteStrobe(WriteStrobe),
    .FrameData(FrameData), .RowSelect(RowSelect), .FrameDataValid(FrameDataValid),
    .FrameSelect(FrameSelect), .FrameStrobe_I(FrameStrobe_I), .FrameStrobe(FrameStrobe),
    .ConfigError(ConfigError)
`ifdef CONFIG_FRAME_COUNT_EN
    , .FrameCount(FrameCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  row;
    logic [4:0]  fsel;
    logic [19:0] fsi;
    logic        strobe;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: frame protocol in plain terms.
  int          mMode = 0;   // 0 waiting for sync, 1 expecting address, 2 collecting rows
  int          mRow = 0;
  logic [4:0]  mFsel = '0;
  logic [19:0] mFsi = '0;
  bit          mBad = 0;
  bit          mErr = 0;
  int          mCount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mkAddr(input int col, input int idx);
    logic [31:0] w;
    w = '0;
    w[31:27] = col[4:0];
    w[4:0]   = idx[4:0];
    return w;
  endfunction

  task automatic modelStep(input logic [31:0] w);
    exp_t e;
    int col, idx;
    if (mMode == 0) begin
      if (w == SYNC) begin
        mMode = 1; mErr = 0; mCount = 0;
      end
    end else if (mMode == 1) begin
      if (w == DESYNC) mMode = 0;
      else begin
        col = int'(w[31:27]);
        idx = int'(w[4:0]);
        mBad = (col > 16) || (idx > 19);
        mFsel = w[31:27];
        mFsi = '0;
        if (!mBad) mFsi[idx] = 1'b1;
        if (mBad) mErr = 1;
        mRow = 0;
        mMode = 2;
      end
    end else begin
      e.data = w; e.row = mRow[4:0]; e.fsel = mFsel; e.fsi = mFsi;
      e.strobe = (mRow == 15) && !mBad;
      e.cyc = cyc + 1;
      q.push_back(e);
      if (e.strobe) mCount++;
      mRow++;
      if (mRow == 16) mMode = 1;
    end
  endtask

  task automatic modelReset();
    mMode = 0; mRow = 0; mFsel = '0; mFsi = '0; mBad = 0; mErr = 0; mCount = 0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (resetn) begin
      if (FrameDataValid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_row actual row=%0d data=%h expected none", RowSelect, FrameData);
        end else begin
          e = q.pop_front();
          if (FrameData !== e.data || RowSelect !== e.row || FrameSelect !== e.fsel ||
              FrameStrobe_I !== e.fsi || FrameStrobe !== e.strobe || cyc != e.cyc) begin
            errors++;
            $display("FAIL row_out actual d=%h r=%0d sel=%0d si=%h st=%b cyc=%0d expected d=%h r=%0d sel=%0d si=%h st=%b cyc=%0d",
                     FrameData, RowSelect, FrameSelect, FrameStrobe_I, FrameStrobe, cyc,
                     e.data, e.row, e.fsel, e.fsi, e.strobe, e.cyc);
          end
        end
      end else if (FrameStrobe) begin
        checks++;
        errors++;
        $display("FAIL stray_strobe actual FrameStrobe=1 without row expected 0");
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic sendWord(input logic [31:0] w);
    WriteData = w; WriteStrobe = 1'b1;
    modelStep(w);
    @(posedge CLK); #1;
    WriteStrobe = 1'b0;
  endtask

  // gap < 0 means a random 0..3 idle cycles after each word.
  task automatic sendFrame(input int col, input int idx, input int gap, input bit seqData);
    logic [31:0] d;
    sendWord(mkAddr(col, idx));
    idle(gap < 0 ? $urandom_range(0, 3) : gap);
    for (int r = 0; r < 16; r++) begin
      if (seqData) d = r;
      else if ($urandom_range(0, 7) == 0) d = SYNC;
      else d = $urandom;
      sendWord(d);
      idle(gap < 0 ? $urandom_range(0, 3) : gap);
    end
  endtask

  task automatic checkStatic(input string tag);
    chk({tag, "_cfg_error"}, {31'd0, ConfigError}, {31'd0, mErr});
    chk({tag, "_frame_select"}, {27'd0, FrameSelect}, {27'd0, mFsel});
    chk({tag, "_frame_strobe_i"}, {12'd0, FrameStrobe_I}, {12'd0, mFsi});
`ifdef CONFIG_FRAME_COUNT_EN
    chk({tag, "_frame_count"}, {16'd0, FrameCount}, mCount);
`endif
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_data"}, FrameData, 32'd0);
    chk({tag, "_row"}, {27'd0, RowSelect}, 32'd0);
    chk({tag, "_valid"}, {31'd0, FrameDataValid}, 32'd0);
    chk({tag, "_strobe"}, {31'd0, FrameStrobe}, 32'd0);
    chk({tag, "_select"}, {27'd0, FrameSelect}, 32'd0);
    chk({tag, "_strobe_i"}, {12'd0, FrameStrobe_I}, 32'd0);
    chk({tag, "_cfg_error"}, {31'd0, ConfigError}, 32'd0);
`ifdef CONFIG_FRAME_COUNT_EN
    chk({tag, "_frame_count"}, {16'd0, FrameCount}, 32'd0);
`endif
  endtask

  initial begin
    resetn = 1'b1; WriteStrobe = 1'b0; WriteData = '0;
    #2 resetn = 1'b0;
    #1 checkResetOutputs("reset");
    idle(2);
    resetn = 1'b1;
    idle(1);

    // Words before SYNC are ignored.
    for (int i = 0; i < 5; i++) sendWord($urandom & 32'h7FFF_FFFF);
    idle(2);
    checkStatic("presync");

    // Full frame followed back-to-back by a second frame.
    sendWord(SYNC);
    sendFrame(3, 7, 0, 1'b1);
    checkStatic("frame1");
    chk("frame1_onehot", {12'd0, FrameStrobe_I}, 32'h0008_0);
    sendFrame(16, 19, 0, 1'b0);
    checkStatic("frame2");
    chk("frame2_onehot", {12'd0, FrameStrobe_I}, 32'h8_0000);

    // Out-of-range addresses: rows forwarded, no commit, sticky error.
    sendFrame(17, 0, 0, 1'b0);
    checkStatic("badcol");
    sendFrame(0, 20, 1, 1'b0);
    checkStatic("badidx");

    // DESYNC returns to idle; selects hold; error clears only on SYNC.
    sendWord(DESYNC);
    for (int i = 0; i < 4; i++) sendWord(mkAddr(2, 2));
    checkStatic("desync");
    sendWord(SYNC);
    checkStatic("resync");

    // Gapped strobes: one word every third cycle.
    sendFrame(5, 1, 2, 1'b1);
    checkStatic("gapped");

    // Randomised frames including bad addresses and SYNC-valued data words.
    for (int f = 0; f < 6; f++) begin
      sendFrame($urandom_range(0, 18), $urandom_range(0, 22), -1, 1'b0);
      checkStatic("random");
    end

    // Reset after row 8 of a frame: partial frame discarded, no commit.
    sendFrame(4, 4, 0, 1'b1);
    sendWord(mkAddr(9, 12));
    for (int r = 0; r <= 8; r++) sendWord(32'hA000_0000 + r);
    idle(2);
    resetn = 1'b0;
    #1 checkResetOutputs("midreset");
    modelReset();
    idle(1);
    resetn = 1'b1;
    for (int r = 9; r < 16; r++) sendWord(32'hA000_0000 + r);
    idle(5);
    checkStatic("postreset");

    sendWord(SYNC);
    sendFrame(1, 0, 0, 1'b0);
    sendFrame(15, 10, -1, 1'b0);
    idle(2);
    checkStatic("twoframes");

    idle(4);
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
